// File: rtl/demux_lane_arbiter.sv
// Round-robin lane arbiter for a shared Demux32_8; grants once per 4-cycle slot, word held phases 0..3 after a phase-3 accept.
// Lanes wait on lane_ready (one-hot, phase 3 only); optional ARB_STATS_EN adds saturating per-lane grant counters.
module demux_lane_arbiter #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
`ifdef ARB_STATS_EN
  parameter int STAT_W = 8,
`endif
  localparam int ID_W  = $clog2(LANES)
) (
  input  logic                    clk_4f,
  input  logic                    reset_L,
  input  logic [LANES*DATA_W-1:0] lane_data,
  input  logic [LANES-1:0]        lane_valid,
  input  logic [LANES-1:0]        lane_en,
  output logic [LANES-1:0]        lane_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic [ID_W-1:0]         lane_id,
`ifdef ARB_STATS_EN
  output logic [LANES*STAT_W-1:0] grant_cnt,
`endif
  output logic                    frame_sync
);

  logic [1:0]        r_phase;
  logic              r_run;
  logic              r_frame_sync;
  logic              r_valid_out;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_lane_id;
  logic [ID_W-1:0]   r_rr_ptr;

  logic [LANES-1:0]  w_elig;
  logic              w_eval;
  logic              w_found;
  logic              w_grant;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_idx;

  assign w_elig  = lane_valid & lane_en;
  assign w_eval  = r_run & (r_phase == 2'd3);
  assign w_grant = w_eval & w_found;

  // Search starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= LANES; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % LANES);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign lane_ready = w_grant ? (LANES'(1) << w_win) : '0;

  // r_run holds phase at 0 for the first edge after release so frame_sync rises on that edge.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_phase      <= 2'd0;
      r_run        <= 1'b0;
      r_frame_sync <= 1'b0;
      r_valid_out  <= 1'b0;
      r_data       <= '0;
      r_lane_id    <= '0;
      r_rr_ptr     <= ID_W'(LANES - 1);
    end else begin
      if (!r_run) begin
        r_run        <= 1'b1;
        r_phase      <= 2'd0;
        r_frame_sync <= 1'b1;
      end else begin
        r_phase      <= r_phase + 2'd1;
        r_frame_sync <= (r_phase == 2'd3);
      end
      if (w_eval) begin
        if (w_found) begin
          r_data      <= lane_data[int'(w_win)*DATA_W +: DATA_W];
          r_lane_id   <= w_win;
          r_valid_out <= 1'b1;
          r_rr_ptr    <= w_win;
        end else begin
          r_valid_out <= 1'b0;
        end
      end
    end
  end

  assign data_out   = r_data;
  assign valid_out  = r_valid_out;
  assign lane_id    = r_lane_id;
  assign frame_sync = r_frame_sync;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] r_cnt [LANES];

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < LANES; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_grant && (w_win == ID_W'(i)) && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_cnt
    assign grant_cnt[g*STAT_W +: STAT_W] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_demux_lane_arbiter.sv
// Scoreboard bench for demux_lane_arbiter: expected grants queued by stimulus, checked by a phase-0 monitor.
module tb_demux_lane_arbiter;

  logic         clk_4f = 1'b0;
  logic         reset_L;
  logic [127:0] lane_data;
  logic [3:0]   lane_valid;
  logic [3:0]   lane_en;
  logic [3:0]   lane_ready;
  logic [31:0]  data_out;
  logic         valid_out;
  logic [1:0]   lane_id;
  logic         frame_sync;
`ifdef ARB_STATS_EN
  logic [31:0]  grant_cnt;
`endif

  always #5 clk_4f = ~clk_4f;

  demux_lane_arbiter dut (
    .clk_4f     (clk_4f),
    .reset_L    (reset_L),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .lane_en    (lane_en),
    .lane_ready (lane_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .lane_id    (lane_id),
`ifdef ARB_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .frame_sync (frame_sync)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] dat;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT at %0t", name, $time);
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] dat);
    exp_t e;
    e.id  = id;
    e.dat = dat;
    q.push_back(e);
  endtask

  task automatic set_lane(input int i, input logic [31:0] d);
    lane_data[i*32 +: 32] = d;
  endtask

  task automatic slot_start();
    int t = 0;
    @(negedge clk_4f);
    while (!frame_sync && t < 8) begin
      @(negedge clk_4f);
      t++;
    end
    if (!frame_sync) timeout("slot_start");
  endtask

  task automatic wait_ready(output logic [3:0] r);
    int t = 0;
    @(negedge clk_4f);
    while (lane_ready == 4'b0 && t < 16) begin
      @(negedge clk_4f);
      t++;
    end
    if (lane_ready == 4'b0) timeout("wait_ready");
    r = lane_ready;
  endtask

  task automatic do_reset();
    @(negedge clk_4f);
    reset_L = 1'b0;
    repeat (2) @(negedge clk_4f);
    reset_L = 1'b1;
  endtask

  // Counts n grants, checks forbidden lanes never see ready and valid_out has no gap, then withdraws all requests.
  task automatic run_grants(input int n, input logic [3:0] forbid);
    int got = 0;
    int t = 0;
    int drops = 0;
    bit started = 1'b0;
    while (got < n && t < n * 8 + 16) begin
      @(negedge clk_4f);
      t++;
      if (started && !valid_out) drops++;
      if (lane_ready != 4'b0) begin
        chk("forbidden_ready", {60'b0, lane_ready & forbid}, 64'h0);
        got++;
        started = 1'b1;
      end
    end
    if (got < n) timeout("run_grants");
    chk("valid_gap", 64'(drops), 64'h0);
    @(posedge clk_4f);
    #1 lane_valid = 4'b0;
    slot_start();
    slot_start();
  endtask

  always @(negedge clk_4f) begin
    if (reset_L === 1'b1 && frame_sync === 1'b1 && valid_out === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon_unexpected: word %0h lane %0d with empty scoreboard at %0t", data_out, lane_id, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_word", {30'b0, lane_id, data_out}, {30'b0, e.id, e.dat});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    n_vec      = 0;
    n_err      = 0;
    reset_L    = 1'b0;
    lane_data  = '0;
    lane_valid = 4'b0;
    lane_en    = 4'hF;

    #2 chk("rst_outputs", {24'b0, valid_out, data_out, lane_id, lane_ready, frame_sync}, 64'h0);
    repeat (2) @(negedge clk_4f);
    reset_L = 1'b1;
    @(negedge clk_4f);
    chk("first_fsync", {63'b0, frame_sync}, 64'h1);

    // single requester on lane 2, word held exactly one slot
    slot_start();
    set_lane(2, 32'hDEADBEEF);
    lane_valid = 4'b0100;
    push(2'd2, 32'hDEADBEEF);
    wait_ready(r);
    chk("t2_ready", {60'b0, r}, 64'h4);
    @(posedge clk_4f);
    #1 lane_valid = 4'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4f);
      chk("t2_hold", {29'b0, valid_out, lane_id, data_out}, {29'b0, 1'b1, 2'd2, 32'hDEADBEEF});
    end
    @(negedge clk_4f);
    chk("t2_end", {63'b0, valid_out}, 64'h0);

    // two idle slots after a grant: data holds, valid low, no ready
    slot_start();
    set_lane(0, 32'h12345678);
    lane_valid = 4'b0001;
    push(2'd0, 32'h12345678);
    wait_ready(r);
    @(posedge clk_4f);
    #1 lane_valid = 4'b0;
    slot_start();
    slot_start();
    for (int k = 0; k < 8; k++) begin
      chk("t5_idle", {27'b0, valid_out, lane_ready, data_out}, {27'b0, 1'b0, 4'b0, 32'h12345678});
      @(negedge clk_4f);
    end

    // async reset in the middle of a granted slot
    slot_start();
    set_lane(3, 32'h33333333);
    lane_valid = 4'b1000;
    push(2'd3, 32'h33333333);
    wait_ready(r);
    @(posedge clk_4f);
    #1 lane_valid = 4'b0;
    @(negedge clk_4f);
    @(negedge clk_4f);
    #1 reset_L = 1'b0;
    #1 chk("t1_async_rst", {24'b0, valid_out, data_out, lane_id, lane_ready, frame_sync}, 64'h0);
    repeat (2) @(negedge clk_4f);
    reset_L = 1'b1;
    @(negedge clk_4f);
    chk("t1_fsync_first", {63'b0, frame_sync}, 64'h1);
    @(negedge clk_4f);
    chk("t1_fsync_ph1", {63'b0, frame_sync}, 64'h0);
    repeat (3) @(negedge clk_4f);
    chk("t1_fsync_wrap", {63'b0, frame_sync}, 64'h1);

    // all lanes requesting after reset: 0,1,2,3,0,1
    slot_start();
    for (int i = 0; i < 4; i++) set_lane(i, 32'hC0DE0000 | 32'(i));
    push(2'd0, 32'hC0DE0000);
    push(2'd1, 32'hC0DE0001);
    push(2'd2, 32'hC0DE0002);
    push(2'd3, 32'hC0DE0003);
    push(2'd0, 32'hC0DE0000);
    push(2'd1, 32'hC0DE0001);
    lane_valid = 4'hF;
    run_grants(6, 4'b0000);

    // masked lanes 0 and 2: 1,3,1,3
    do_reset();
    lane_en = 4'b1010;
    slot_start();
    push(2'd1, 32'hC0DE0001);
    push(2'd3, 32'hC0DE0003);
    push(2'd1, 32'hC0DE0001);
    push(2'd3, 32'hC0DE0003);
    lane_valid = 4'hF;
    run_grants(4, 4'b0101);
    lane_en = 4'hF;

`ifdef ARB_STATS_EN
    do_reset();
    @(negedge clk_4f);
    chk("cnt_reset", {32'b0, grant_cnt}, 64'h0);
    slot_start();
    set_lane(1, 32'h11111111);
    for (int k = 0; k < 3; k++) push(2'd1, 32'h11111111);
    lane_valid = 4'b0010;
    run_grants(3, 4'b0000);
    chk("cnt_three", {32'b0, grant_cnt}, 64'h0000_0300);
    slot_start();
    for (int k = 0; k < 300; k++) push(2'd1, 32'h11111111);
    lane_valid = 4'b0010;
    run_grants(300, 4'b0000);
    chk("cnt_saturate", {32'b0, grant_cnt}, 64'h0000_FF00);
`endif

    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
